mem_arbiter: RTL and testbench

Arbitrates the CPU's single-ported memory between instruction fetch (program-counter side) and data access (load/store side). Holds one outstanding RAM transaction at a time, gives data priority over fetch, and returns one-cycle hit pulses to the requester that was served. Counts consecutive RAM errors and raises a sticky fault once a retry limit is exceeded. Sits between the datapath's request interfaces and the RAM/memory-control block.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/mem_arbiter_if.sv | 63 ++++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared CPU type definitions: machine word, RAM handshake state
//             and the memory-arbiter FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int c_WORD_W = 32;

    typedef logic [c_WORD_W-1:0] word_t;

    // Response code returned by the RAM/memory-control block each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the fetch-side, data-side and RAM-side signals of the
//             memory arbiter.
//  Ports    : fetch  - iREN, iaddr, halt (in to arbiter); ihit, iload (out)
//             data   - dREN, dWEN, daddr, dstore (in); dhit, dload (out)
//             RAM    - ramload, ramstate (in); ramREN, ramWEN, ramaddr,
//                      ramstore (out)
//             status - err, fault (out)
//             Modport arb is the arbiter view, modport tb the environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    // Instruction fetch side
    logic      iREN;
    word_t     iaddr;
    logic      ihit;
    word_t     iload;
    logic      halt;

    // Data side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dhit;
    word_t     dload;

    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // Status
    logic      err;
    logic      fault;

    modport arb (
        input  iREN, iaddr, halt,
        input  dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output ihit, iload, dhit, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output err, fault
    );

    modport tb (
        output iREN, iaddr, halt,
        output dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  ihit, iload, dhit, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  err, fault
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one single-ported RAM between instruction fetch and data
//             load/store. One transaction outstanding at a time, data wins
//             over fetch, one-cycle hit pulse back to the served requester.
//             Consecutive RAM errors are counted; exceeding MAX_RETRY sets a
//             sticky fault which blocks further fetch grants.
//  Ports    : CLK   - system clock, rising edge
//             nRST  - synchronous active-low reset
//             bus   - mem_arbiter_if.arb (fetch, data, RAM and status signals)
//  Params   : MAX_RETRY - consecutive ERROR responses tolerated before fault
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_RETRY = 3
) (
    input  logic       CLK,
    input  logic       nRST,
    mem_arbiter_if.arb bus
);

    // Counter must hold values up to MAX_RETRY and is at least 2 bits wide.
    localparam int c_CNT_W = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;
    localparam logic [c_CNT_W-1:0] c_RETRY_LIMIT = c_CNT_W'(MAX_RETRY);

    arb_state_t         r_state;
    logic               r_ram_ren;
    logic               r_ram_wen;
    word_t              r_addr;
    word_t              r_store;
    logic [c_CNT_W-1:0] r_retry;
    logic               r_fault;

    logic               w_active;
    logic               w_access;
    logic               w_error;
    logic               w_data_req;
    logic               w_fetch_req;
    logic               w_ihit;
    logic               w_dhit;

    assign w_active    = (r_state != IDLE);
    assign w_access    = w_active && (bus.ramstate == ACCESS);
    assign w_error     = w_active && (bus.ramstate == ERROR);
    assign w_data_req  = bus.dREN | bus.dWEN;
    // Data grants ignore halt/fault; only fetch is gated by them.
    assign w_fetch_req = bus.iREN & ~bus.halt & ~r_fault;

    assign w_ihit = (r_state == IFETCH)  && (bus.ramstate == ACCESS);
    assign w_dhit = (r_state == DACCESS) && (bus.ramstate == ACCESS);

    // The RAM-side registers double as the latched request copy: they are
    // loaded on grant and cleared on completion, so IDLE drives all zeros.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
            r_addr    <= '0;
            r_store   <= '0;
            r_retry   <= '0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_data_req) begin
                        r_state   <= DACCESS;
                        r_ram_ren <= ~bus.dWEN;
                        r_ram_wen <= bus.dWEN;
                        r_addr    <= bus.daddr;
                        r_store   <= bus.dstore;
                    end else if (w_fetch_req) begin
                        r_state   <= IFETCH;
                        r_ram_ren <= 1'b1;
                        r_ram_wen <= 1'b0;
                        r_addr    <= bus.iaddr;
                        r_store   <= '0;
                    end
                end

                IFETCH, DACCESS: begin
                    // FREE/BUSY fall through and hold everything.
                    if (w_access || w_error) begin
                        r_state   <= IDLE;
                        r_ram_ren <= 1'b0;
                        r_ram_wen <= 1'b0;
                        r_addr    <= '0;
                        r_store   <= '0;
                    end
                    if (w_access) begin
                        r_retry <= '0;
                    end else if (w_error) begin
                        // Incrementing past the limit trips the fault instead.
                        if (r_retry >= c_RETRY_LIMIT) begin
                            r_fault <= 1'b1;
                            r_retry <= '0;
                        end else begin
                            r_retry <= r_retry + c_CNT_W'(1);
                        end
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_ram_ren <= 1'b0;
                    r_ram_wen <= 1'b0;
                    r_addr    <= '0;
                    r_store   <= '0;
                end
            endcase
        end
    end

    assign bus.ramREN   = r_ram_ren;
    assign bus.ramWEN   = r_ram_wen;
    assign bus.ramaddr  = r_addr;
    assign bus.ramstore = r_store;

    assign bus.ihit  = w_ihit;
    assign bus.iload = w_ihit ? bus.ramload : '0;
    assign bus.dhit  = w_dhit;
    assign bus.dload = w_dhit ? bus.ramload : '0;

    assign bus.err   = w_error;
    assign bus.fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: directed scenarios with
//             literal expectations, then randomized traffic compared every
//             cycle against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int MAX_RETRY = 3;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_RETRY(MAX_RETRY)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus.arb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: at most one granted transaction in a queue, plus a
    // count of consecutive errors and a sticky fault flag.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        is_data;
        logic        write;
        logic [31:0] addr;
        logic [31:0] store;
    } txn_t;

    txn_t txn_q[$];
    int   m_retry = 0;
    bit   m_fault = 1'b0;
    bit   seen_ihit = 1'b0;
    bit   seen_dhit = 1'b0;

    initial begin : model_update
        forever begin
            @(posedge clk);
            if (!nrst) begin
                txn_q.delete();
                m_retry = 0;
                m_fault = 1'b0;
            end else if (txn_q.size() == 0) begin
                if (bus.dREN || bus.dWEN)
                    txn_q.push_back({1'b1, bus.dWEN, bus.daddr, bus.dstore});
                else if (bus.iREN && !bus.halt && !m_fault)
                    txn_q.push_back({1'b0, 1'b0, bus.iaddr, 32'h0});
            end else if (bus.ramstate == ACCESS) begin
                void'(txn_q.pop_front());
                m_retry = 0;
            end else if (bus.ramstate == ERROR) begin
                void'(txn_q.pop_front());
                m_retry = m_retry + 1;
                if (m_retry > MAX_RETRY) begin
                    m_fault = 1'b1;
                    m_retry = 0;
                end
            end
        end
    end

    initial begin : compare
        txn_t t;
        bit   busy;
        bit   e_ihit;
        bit   e_dhit;
        forever begin
            @(negedge clk);
            busy = (txn_q.size() != 0);
            t    = busy ? txn_q[0] : '0;
            e_ihit = busy && !t.is_data && (bus.ramstate == ACCESS);
            e_dhit = busy &&  t.is_data && (bus.ramstate == ACCESS);
            chk("m_ramREN",   bus.ramREN,   busy && !(t.is_data && t.write));
            chk("m_ramWEN",   bus.ramWEN,   busy && t.is_data && t.write);
            chk("m_ramaddr",  bus.ramaddr,  busy ? t.addr : 32'h0);
            chk("m_ramstore", bus.ramstore, busy ? t.store : 32'h0);
            chk("m_ihit",     bus.ihit,     e_ihit);
            chk("m_iload",    bus.iload,    e_ihit ? bus.ramload : 32'h0);
            chk("m_dhit",     bus.dhit,     e_dhit);
            chk("m_dload",    bus.dload,    e_dhit ? bus.ramload : 32'h0);
            chk("m_err",      bus.err,      busy && (bus.ramstate == ERROR));
            chk("m_fault",    bus.fault,    m_fault);
            seen_ihit = e_ihit;
            seen_dhit = e_dhit;
        end
    end

    // Inputs change 1 time unit after the rising edge; looks happen on the
    // falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : driver
        int  err_cnt;
        bit  i_act;
        bit  d_act;
        int  rs;
        int  kind;

        bus.iREN = 1'b1;  bus.iaddr  = 32'h40; bus.halt = 1'b0;
        bus.dREN = 1'b0;  bus.dWEN   = 1'b0;   bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;

        // Reset held for two edges with a fetch pending.
        tick(); tick();
        look();
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ihit", bus.ihit, 0);
        chk("rst_iload", bus.iload, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_err", bus.err, 0);
        tick();

        // Release: fetch 0x40 granted on the next edge, zero-wait ACCESS.
        nrst = 1'b1;
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h8C220004;
        tick();
        look();
        chk("fetch_ramREN", bus.ramREN, 1);
        chk("fetch_ramaddr", bus.ramaddr, 32'h40);
        chk("fetch_ihit", bus.ihit, 1);
        chk("fetch_iload", bus.iload, 32'h8C220004);
        tick();
        bus.iREN = 1'b0;
        look();
        chk("fetch_after_ramREN", bus.ramREN, 0);
        chk("fetch_after_ihit", bus.ihit, 0);
        chk("fetch_after_iload", bus.iload, 0);

        // Contention: data write beats a simultaneous fetch.
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        bus.ramstate = BUSY;
        tick();
        look();
        chk("cont_ramWEN", bus.ramWEN, 1);
        chk("cont_ramREN", bus.ramREN, 0);
        chk("cont_ramaddr", bus.ramaddr, 32'h100);
        chk("cont_ramstore", bus.ramstore, 32'hDEADBEEF);
        tick();
        bus.ramstate = ACCESS;
        bus.daddr    = 32'h999;
        look();
        chk("cont_dhit", bus.dhit, 1);
        chk("cont_ramaddr_latched", bus.ramaddr, 32'h100);
        tick();
        bus.dWEN = 1'b0;
        bus.ramstate = BUSY;
        look();
        chk("cont_bubble_ramREN", bus.ramREN, 0);
        chk("cont_bubble_ramWEN", bus.ramWEN, 0);
        tick();
        look();
        chk("cont_fetch_ramREN", bus.ramREN, 1);
        chk("cont_fetch_ramaddr", bus.ramaddr, 32'h44);
        tick();
        bus.ramstate = ACCESS;
        look();
        chk("cont_fetch_ihit", bus.ihit, 1);
        tick();
        bus.iREN = 1'b0;

        // Wait states: BUSY three cycles, then ACCESS.
        bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = BUSY;
        tick();
        for (int k = 0; k < 3; k++) begin
            look();
            chk("ws_ramREN", bus.ramREN, 1);
            chk("ws_ramaddr", bus.ramaddr, 32'h200);
            chk("ws_dhit", bus.dhit, 0);
            tick();
            bus.daddr = $urandom;
            if (k == 2) begin
                bus.ramstate = ACCESS;
                bus.ramload  = 32'h12345678;
            end
        end
        look();
        chk("ws_last_ramREN", bus.ramREN, 1);
        chk("ws_last_ramaddr", bus.ramaddr, 32'h200);
        chk("ws_dhit_final", bus.dhit, 1);
        chk("ws_dload", bus.dload, 32'h12345678);
        tick();
        bus.dREN = 1'b0;
        look();
        chk("ws_dhit_once", bus.dhit, 0);

        // Errors: four consecutive ERROR responses to a held fetch.
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.ramstate = ERROR;
        err_cnt = 0;
        for (int e = 0; e < 4; e++) begin
            tick();
            look();
            chk("errs_ramREN", bus.ramREN, 1);
            chk("errs_ihit", bus.ihit, 0);
            chk("errs_fault_before", bus.fault, 0);
            if (bus.err) err_cnt++;
            tick();
            look();
            chk("errs_fault_after", bus.fault, (e == 3) ? 1 : 0);
        end
        chk("errs_pulses", err_cnt, 4);
        for (int k = 0; k < 6; k++) begin
            tick();
            look();
            chk("fault_no_fetch", bus.ramREN, 0);
        end
        tick();
        bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = ACCESS; bus.ramload = 32'hCAFE0001;
        tick();
        look();
        chk("fault_data_dhit", bus.dhit, 1);
        chk("fault_data_dload", bus.dload, 32'hCAFE0001);
        chk("fault_sticky", bus.fault, 1);
        tick();
        bus.dREN = 1'b0; bus.iREN = 1'b0;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        look();
        chk("fault_cleared", bus.fault, 0);

        // Halt during a fetch does not abort it, but blocks later fetches.
        bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = BUSY;
        tick();
        bus.halt = 1'b1;
        look();
        chk("halt_ramREN", bus.ramREN, 1);
        tick();
        bus.ramstate = ACCESS;
        look();
        chk("halt_ihit", bus.ihit, 1);
        tick();
        bus.iREN = 1'b0;
        tick();
        bus.iREN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            look();
            chk("halt_blocked", bus.ramREN, 0);
        end
        bus.halt = 1'b0;
        tick();
        look();
        chk("unhalt_ramREN", bus.ramREN, 1);
        chk("unhalt_ramaddr", bus.ramaddr, 32'h500);
        chk("unhalt_ihit", bus.ihit, 1);
        tick();
        bus.iREN = 1'b0;

        // Randomized traffic with well-behaved requesters.
        i_act = 1'b0;
        d_act = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (i_act && seen_ihit) begin
                bus.iREN = 1'b0; i_act = 1'b0;
            end else if (!i_act && $urandom_range(0, 2) == 0) begin
                bus.iREN = 1'b1; i_act = 1'b1;
            end
            if (d_act && seen_dhit) begin
                bus.dREN = 1'b0; bus.dWEN = 1'b0; d_act = 1'b0;
            end else if (!d_act && $urandom_range(0, 3) == 0) begin
                kind = $urandom_range(0, 2);
                bus.dREN = (kind != 1);
                bus.dWEN = (kind != 0);
                d_act = 1'b1;
            end
            bus.iaddr   = $urandom;
            bus.daddr   = $urandom;
            bus.dstore  = $urandom;
            bus.ramload = $urandom;
            bus.halt    = ($urandom_range(0, 9) == 0);
            rs = $urandom_range(0, 19);
            bus.ramstate = (rs < 10) ? ACCESS : (rs < 13) ? FREE : (rs < 18) ? BUSY : ERROR;
            nrst = ($urandom_range(0, 249) != 0);
        end
        tick();
        nrst = 1'b1;
        look();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
